// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Register-write scoreboard and ID-stage hazard controller for the
//   five-stage pipeline. Keeps a small in-flight counter per general register
//   (r1..r31) plus a "youngest writer is an unreturned load" flag, and derives
//   the ID stall from them.
//
//   Optional feature macro: SCB_FWD_EN
//     defined   : forwarding exists, only load-use hazards stall
//     undefined : no forwarding, any in-flight writer of a source stalls
//
// Ports
//   clk, resetn                 pipeline clock, async active-low reset
//   issue_valid/we/dest/is_load ID->EX transfer of a (possibly) writing instr
//   rd_en1/2, rd_addr1/2        source reads of the instruction in ID
//   id_we, id_dest              destination of the instruction in ID
//   ld_done, ld_dest            load data returned at MEM->WB
//   wb_commit, wb_dest          register-file write by WB
//   flush                       drop all in-flight tracking
//   stall_id                    ID must not issue this cycle
//   busy, inflight              any / total writes in flight
//   err                         sticky counter underflow/overflow
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       issue_valid,
  input  logic       issue_we,
  input  logic [4:0] issue_dest,
  input  logic       issue_is_load,
  input  logic       rd_en1,
  input  logic       rd_en2,
  input  logic [4:0] rd_addr1,
  input  logic [4:0] rd_addr2,
  input  logic       id_we,
  input  logic [4:0] id_dest,
  input  logic       ld_done,
  input  logic [4:0] ld_dest,
  input  logic       wb_commit,
  input  logic [4:0] wb_dest,
  input  logic       flush,
  output logic       stall_id,
  output logic       busy,
  output logic [3:0] inflight,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Flattened views of per-register state; entry 0 is r0 and always reads 0.
  logic [CNT_W-1:0] w_cnt [32];
  logic             w_ldp [32];

  logic [3:0] r_inflight;
  logic       r_err;

  logic w_iss_req, w_com_req, w_pair;
  logic w_inc, w_dec, w_err_set;

  assign w_iss_req = issue_valid & issue_we & (issue_dest != 5'd0);
  assign w_com_req = wb_commit & (wb_dest != 5'd0);
  // Issue and commit to the same register cancel out: no count change, no error.
  assign w_pair    = w_iss_req & w_com_req & (issue_dest == wb_dest);

  assign w_inc     = w_iss_req & (w_pair | (w_cnt[issue_dest] != CNT_MAX));
  assign w_dec     = w_com_req & (w_pair | (w_cnt[wb_dest] != '0));
  assign w_err_set = (w_iss_req & ~w_pair & (w_cnt[issue_dest] == CNT_MAX)) |
                     (w_com_req & ~w_pair & (w_cnt[wb_dest] == '0));

  assign w_cnt[0] = '0;
  assign w_ldp[0] = 1'b0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    logic [CNT_W-1:0] r_cnt;
    logic             r_ldp;
    logic             w_iss_hit, w_com_hit, w_ld_hit;

    assign w_iss_hit = issue_valid & issue_we & (issue_dest == 5'(gi));
    assign w_com_hit = wb_commit & (wb_dest == 5'(gi));
    assign w_ld_hit  = ld_done & (ld_dest == 5'(gi));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_cnt <= '0;
        r_ldp <= 1'b0;
      end else if (flush) begin
        r_cnt <= '0;
        r_ldp <= 1'b0;
      end else begin
        if (w_iss_hit && !w_com_hit && r_cnt != CNT_MAX)
          r_cnt <= r_cnt + 1'b1;
        else if (w_com_hit && !w_iss_hit && r_cnt != '0)
          r_cnt <= r_cnt - 1'b1;

        // A counted issue makes the new instruction the youngest writer and
        // wins over a same-cycle load return; a rejected issue changes nothing.
        if (w_iss_hit && (w_com_hit || r_cnt != CNT_MAX))
          r_ldp <= issue_is_load;
        else if (w_ld_hit)
          r_ldp <= 1'b0;
      end
    end

    assign w_cnt[gi] = r_cnt;
    assign w_ldp[gi] = r_ldp;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inflight <= 4'd0;
      r_err      <= 1'b0;
    end else if (flush) begin
      r_inflight <= 4'd0;
    end else begin
      if (w_inc && !w_dec)
        r_inflight <= r_inflight + 4'd1;
      else if (w_dec && !w_inc)
        r_inflight <= r_inflight - 4'd1;
      if (w_err_set)
        r_err <= 1'b1;
    end
  end

  function automatic logic hazard(input logic en, input logic [4:0] a);
`ifdef SCB_FWD_EN
    return en & (a != 5'd0) & (w_cnt[a] != '0) & w_ldp[a];
`else
    return en & (a != 5'd0) & (w_cnt[a] != '0);
`endif
  endfunction

  logic w_dest_full;
  assign w_dest_full = id_we & (id_dest != 5'd0) & (w_cnt[id_dest] == CNT_MAX);

  assign stall_id = hazard(rd_en1, rd_addr1) | hazard(rd_en2, rd_addr2) | w_dest_full;
  assign busy     = (r_inflight != 4'd0);
  assign inflight = r_inflight;
  assign err      = r_err;

endmodule
